// File: rtl/systolic_result_collector_if.sv
// Bus bundle between the systolic array stream, the result collector and its consumer.
// The collector connects as slave; the array/consumer side (or a bench) connects as master.
interface systolic_result_collector_if #(
    parameter int unsigned DIN_WIDTH = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_WIDTH = 8
);
    localparam int unsigned IN_W  = 2 * DIN_WIDTH;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH_W  = $clog2(IN_W);

    logic [IN_W-1:0]      in_data;
    logic                 in_valid;
    logic [IDX_W-1:0]     in_idx;
    logic [SH_W-1:0]      shift;
    logic [OUT_WIDTH-1:0] m_data [N];
    logic                 m_err;
    logic                 m_valid;
    logic                 m_ready;
    logic                 ovf;
    logic                 ovf_sticky;
    logic                 ovf_clr;

    modport master (
        output in_data, in_valid, in_idx, shift, m_ready, ovf_clr,
        input  m_data, m_err, m_valid, ovf, ovf_sticky
    );

    modport slave (
        input  in_data, in_valid, in_idx, shift, m_ready, ovf_clr,
        output m_data, m_err, m_valid, ovf, ovf_sticky
    );
endinterface

// File: rtl/systolic_result_collector.sv
// Reassembles the array's serialized accumulator stream into N-element vectors,
// requantizes each element and buffers finished vectors in a 2-entry FIFO.
module systolic_result_collector #(
    parameter int unsigned DIN_WIDTH = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_result_collector_if.slave bus
);
    localparam int unsigned IN_W  = 2 * DIN_WIDTH;
    localparam int unsigned T_W   = IN_W + 1;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH_W  = $clog2(IN_W);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e               state_q, state_d;
    logic [SH_W-1:0]      frame_shift_q;
    logic [SH_W-1:0]      shift_eff;
    logic [OUT_WIDTH-1:0] slot_q [N];
    logic [N-1:0]         mask_q, mask_d;
    logic                 err_q, err_d;

    logic                 idx_ok;
    logic                 wr_c, complete_c, dup_c;
    logic [T_W-1:0]       rnd, t_sum, r_shr;
    logic [OUT_WIDTH-1:0] q_elem;
    logic [OUT_WIDTH-1:0] push_data [N];
    logic                 push_err;

    logic [OUT_WIDTH-1:0] mem_data [2][N];
    logic [1:0]           mem_err;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count_q;
    logic                 pop_c, push_c, ovf_c;
    logic                 ovf_q, sticky_q;

    // Indices past N-1 only exist when N is not a power of two.
    if ((1 << IDX_W) == N) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_part
        assign idx_ok = (bus.in_idx < IDX_W'(N));
    end

    assign wr_c       = bus.in_valid && idx_ok;
    assign complete_c = wr_c && (bus.in_idx == IDX_W'(N - 1));
    assign dup_c      = wr_c && mask_q[bus.in_idx];

    // FSM next state; first element of a frame sees the shift port directly.
    always_comb begin
        state_d   = state_q;
        shift_eff = frame_shift_q;
        unique case (state_q)
            IDLE: begin
                shift_eff = bus.shift;
                if (bus.in_valid && !complete_c) state_d = COLLECT;
            end
            COLLECT: begin
                if (complete_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Rounding right shift with unsigned saturation.
    always_comb begin
        rnd = '0;
        if (shift_eff != '0) rnd = T_W'(1) << (shift_eff - SH_W'(1));
        t_sum  = T_W'(bus.in_data) + rnd;
        r_shr  = t_sum >> shift_eff;
        q_elem = (r_shr > T_W'(OUT_MAX)) ? OUT_MAX : r_shr[OUT_WIDTH-1:0];
    end

    // Frame assembly including the element accepted this cycle.
    always_comb begin
        mask_d = mask_q;
        if (wr_c) mask_d[bus.in_idx] = 1'b1;
        err_d    = err_q | (bus.in_valid && !idx_ok) | dup_c;
        push_err = err_d | (mask_d != '1);
        for (int i = 0; i < N; i++) begin
            push_data[i] = '0;
            if (mask_d[i])
                push_data[i] = (wr_c && bus.in_idx == IDX_W'(i)) ? q_elem : slot_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q        <= '0;
            err_q         <= 1'b0;
            frame_shift_q <= '0;
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else begin
            if (wr_c) slot_q[bus.in_idx] <= q_elem;
            if (complete_c) begin
                mask_q <= '0;
                err_q  <= 1'b0;
            end else begin
                mask_q <= mask_d;
                err_q  <= err_d;
            end
            if (state_q == IDLE && bus.in_valid) frame_shift_q <= bus.shift;
        end
    end

    assign pop_c  = (count_q != 2'd0) && bus.m_ready;
    assign push_c = complete_c && ((count_q != 2'd2) || pop_c);
    assign ovf_c  = complete_c && (count_q == 2'd2) && !pop_c;

    // Two-entry ping-pong FIFO; a full FIFO still accepts a push alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < 2; e++)
                for (int i = 0; i < N; i++) mem_data[e][i] <= '0;
            mem_err  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count_q  <= 2'd0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (push_c) begin
                for (int i = 0; i < N; i++) mem_data[wr_ptr][i] <= push_data[i];
                mem_err[wr_ptr] <= push_err;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop_c) rd_ptr <= ~rd_ptr;
            if (push_c && !pop_c)      count_q <= count_q + 2'd1;
            else if (!push_c && pop_c) count_q <= count_q - 2'd1;
            ovf_q <= ovf_c;
            if (ovf_c)            sticky_q <= 1'b1;
            else if (bus.ovf_clr) sticky_q <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) bus.m_data[i] = mem_data[rd_ptr][i];
    end

    assign bus.m_valid    = (count_q != 2'd0);
    assign bus.m_err      = mem_err[rd_ptr];
    assign bus.ovf        = ovf_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed, table-driven bench for systolic_result_collector (N=4, 16-bit in, 8-bit out).
module tb_systolic_result_collector;
    localparam int unsigned TB_N = 4;

    typedef struct {
        logic        v;
        logic [1:0]  idx;
        logic [15:0] din;
        logic [3:0]  sh;
        logic        rdy;
        logic        clr;
        logic        mv;
        logic        me;
        logic [31:0] md;
        logic        ovf;
        logic        st;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t tbl[$];
    logic [8*TB_N-1:0] md_pk;

    systolic_result_collector_if #(.DIN_WIDTH(8), .N(TB_N), .OUT_WIDTH(8)) bus ();

    systolic_result_collector #(.DIN_WIDTH(8), .N(TB_N), .OUT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        md_pk = '0;
        for (int i = 0; i < TB_N; i++) md_pk[8*i +: 8] = bus.m_data[i];
    end

    task automatic add(input logic v, input logic [1:0] idx, input logic [15:0] din,
                       input logic [3:0] sh, input logic rdy, input logic clr,
                       input logic mv, input logic me, input logic [31:0] md,
                       input logic ovf, input logic st);
        vec_t r;
        r.v = v; r.idx = idx; r.din = din; r.sh = sh; r.rdy = rdy; r.clr = clr;
        r.mv = mv; r.me = me; r.md = md; r.ovf = ovf; r.st = st;
        tbl.push_back(r);
    endtask

    // full=1 also compares m_err/m_data when no vector is expected.
    task automatic check_out(input string name, input bit full, input vec_t r);
        bit bad;
        n_vec++;
        bad = (bus.m_valid !== r.mv) || (bus.ovf !== r.ovf) || (bus.ovf_sticky !== r.st);
        if (r.mv || full) bad = bad || (bus.m_err !== r.me) || (md_pk !== r.md);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got mv=%0b me=%0b md=%h ovf=%0b st=%0b, want mv=%0b me=%0b md=%h ovf=%0b st=%0b",
                     name, bus.m_valid, bus.m_err, md_pk, bus.ovf, bus.ovf_sticky,
                     r.mv, r.me, r.md, r.ovf, r.st);
        end
    endtask

    task automatic apply(input string name, input vec_t r);
        @(negedge clk);
        bus.in_valid = r.v;
        bus.in_idx   = r.idx;
        bus.in_data  = r.din;
        bus.shift    = r.sh;
        bus.m_ready  = r.rdy;
        bus.ovf_clr  = r.clr;
        @(posedge clk);
        #1;
        check_out(name, 1'b0, r);
    endtask

    task automatic apply_row(input string name, input logic v, input logic [1:0] idx,
                             input logic [15:0] din, input logic rdy,
                             input logic mv, input logic me, input logic [31:0] md);
        vec_t r;
        r.v = v; r.idx = idx; r.din = din; r.sh = 4'd0; r.rdy = rdy; r.clr = 1'b0;
        r.mv = mv; r.me = me; r.md = md; r.ovf = 1'b0; r.st = 1'b0;
        apply(name, r);
    endtask

    initial begin
        vec_t z;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_data = '0; bus.shift = '0;
        bus.m_ready = 1'b0; bus.ovf_clr = 1'b0;

        // basic saturation, shift 0
        add(1,0,300,0,1,0, 0,0,0,0,0);
        add(1,1,255,0,1,0, 0,0,0,0,0);
        add(1,2,256,0,1,0, 0,0,0,0,0);
        add(1,3,  1,0,1,0, 1,0,32'h01FF_FFFF,0,0);
        add(0,0,  0,0,1,0, 0,0,0,0,0);
        // rounding, shift latched at frame start
        add(1,0,3,1,1,0, 0,0,0,0,0);
        add(1,1,2,4,1,0, 0,0,0,0,0);
        add(1,2,1,4,1,0, 0,0,0,0,0);
        add(1,3,0,4,1,0, 1,0,32'h0001_0102,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,0);
        add(1,0,65535,15,1,0, 0,0,0,0,0);
        add(1,1,0,0,1,0, 0,0,0,0,0);
        add(1,2,0,0,1,0, 0,0,0,0,0);
        add(1,3,0,0,1,0, 1,0,32'h0000_0002,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,0);
        // overflow under backpressure; clr on the ovf cycle loses to set
        add(1,0,1,0,0,0, 0,0,0,0,0);
        add(1,1,2,0,0,0, 0,0,0,0,0);
        add(1,2,3,0,0,0, 0,0,0,0,0);
        add(1,3,4,0,0,0, 1,0,32'h0403_0201,0,0);
        for (int i = 0; i < 4; i++) add(1,2'(i),16'(5+i),0,0,0, 1,0,32'h0403_0201,0,0);
        add(1,0, 9,0,0,0, 1,0,32'h0403_0201,0,0);
        add(1,1,10,0,0,0, 1,0,32'h0403_0201,0,0);
        add(1,2,11,0,0,0, 1,0,32'h0403_0201,0,0);
        add(1,3,12,0,0,1, 1,0,32'h0403_0201,1,1);
        add(0,0, 0,0,0,0, 1,0,32'h0403_0201,0,1);
        add(0,0, 0,0,1,0, 1,0,32'h0807_0605,0,1);
        add(0,0, 0,0,1,1, 0,0,0,0,0);
        // full FIFO with a pop on the completing cycle
        add(1,0,16'h10,0,0,0, 0,0,0,0,0);
        add(1,1,16'h11,0,0,0, 0,0,0,0,0);
        add(1,2,16'h12,0,0,0, 0,0,0,0,0);
        add(1,3,16'h13,0,0,0, 1,0,32'h1312_1110,0,0);
        for (int i = 0; i < 4; i++) add(1,2'(i),16'(32+i),0,0,0, 1,0,32'h1312_1110,0,0);
        for (int i = 0; i < 3; i++) add(1,2'(i),16'(48+i),0,0,0, 1,0,32'h1312_1110,0,0);
        add(1,3,16'h33,0,1,0, 1,0,32'h2322_2120,0,0);
        add(0,0,0,0,1,0, 1,0,32'h3332_3130,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,0);
        // protocol errors: duplicate + missing, then lone idx 3
        add(1,0,7,0,1,0, 0,0,0,0,0);
        add(1,0,9,0,1,0, 0,0,0,0,0);
        add(1,3,5,0,1,0, 1,1,32'h0500_0009,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,0);
        add(1,0,1,0,1,0, 0,0,0,0,0);
        add(1,1,1,0,1,0, 0,0,0,0,0);
        add(1,2,1,0,1,0, 0,0,0,0,0);
        add(1,3,1,0,1,0, 1,0,32'h0101_0101,0,0);
        add(1,3,2,0,1,0, 1,1,32'h0200_0000,0,0);
        add(0,0,0,0,1,0, 0,0,0,0,0);

        #1;
        z.v = 0; z.idx = 0; z.din = 0; z.sh = 0; z.rdy = 0; z.clr = 0;
        z.mv = 0; z.me = 0; z.md = 0; z.ovf = 0; z.st = 0;
        check_out("reset_state", 1'b1, z);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) apply($sformatf("vec%0d", k), tbl[k]);

        // async reset with one vector buffered and a frame half collected
        apply_row("pre_rst0", 1,0,1,0, 0,0,0);
        apply_row("pre_rst1", 1,1,2,0, 0,0,0);
        apply_row("pre_rst2", 1,2,3,0, 0,0,0);
        apply_row("pre_rst3", 1,3,4,0, 1,0,32'h0403_0201);
        apply_row("pre_rst4", 1,0,5,0, 1,0,32'h0403_0201);
        apply_row("pre_rst5", 1,1,6,0, 1,0,32'h0403_0201);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_out("rst_async", 1'b1, z);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply_row("post_rst_idle", 0,0,0,1, 0,0,0);
        apply_row("post_rst0", 1,0,10,1, 0,0,0);
        apply_row("post_rst1", 1,1,20,1, 0,0,0);
        apply_row("post_rst2", 1,2,30,1, 0,0,0);
        apply_row("post_rst3", 1,3,40,1, 1,0,32'h281E_140A);
        apply_row("post_rst4", 0,0,0,1, 0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Downstream stage of the systolic array core: consumes its serialized per-row accumulator stream (data, valid, row index) and reassembles each N-element result vector.
- Requantizes each element (rounding right shift, unsigned saturation) and hands completed vectors to the next stage over a valid/ready interface through a 2-entry vector FIFO.
- The array has no backpressure, so vectors that find the FIFO full are dropped and flagged.

Parameters:
- DIN_WIDTH, 8, array operand width; input element width is 2*DIN_WIDTH.
- N, 4, elements per vector (array dimension).
- OUT_WIDTH, 8, width of each requantized output element.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  2*DIN_WIDTH  accumulator element from the array.
- in_valid  input  1  in_data/in_idx valid this cycle.
- in_idx  input  $clog2(N)  row index of in_data.
- shift  input  $clog2(2*DIN_WIDTH)  right-shift amount; sampled per frame.
- m_data  output  OUT_WIDTH x N (unpacked [N])  requantized vector, head of FIFO.
- m_err  output  1  head vector had a missing, duplicate or out-of-range index.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts head vector.
- ovf  output  1  one-cycle pulse when a completed vector is dropped.
- ovf_sticky  output  1  set by ovf; cleared only by ovf_clr or reset.
- ovf_clr  input  1  clears ovf_sticky.

Behaviour:
- Reset (async, rst=1): state IDLE, slot mask 0, frame err 0, FIFO empty. Outputs: m_valid=0, m_err=0, m_data all 0, ovf=0, ovf_sticky=0.
- FSM IDLE:
  - in_valid=1 moves to COLLECT.
  - If in_idx==N-1 the frame completes in the same cycle and the FSM stays IDLE (N=1 or truncated frame).
  - shift is latched into frame_shift; the first element uses the port value directly.
- FSM COLLECT:
  - Each in_valid writes slot[in_idx] and sets mask[in_idx].
  - in_idx==N-1 completes the frame and returns to IDLE.
- Frame error, which travels with the vector as m_err:
  - in_idx >= N (N not a power of 2): element ignored, err set; does not complete the frame.
  - Write to an already-set mask bit: slot overwritten, err set.
  - At completion, mask (including the N-1 write) not all ones: err set; missing slots output 0.
- Requant, combinational per element at acceptance, stored as OUT_WIDTH:
  - Computed in 2*DIN_WIDTH+1 bits: t = in_data + (s>0 ? 1<<(s-1) : 0), r = t >> s.
  - Result is min(r, 2^OUT_WIDTH-1). Data is unsigned.
- Completion at clock edge T:
  - The assembled vector (including the element accepted at T) plus err is pushed into the FIFO.
  - m_valid is high from cycle T+1 if the FIFO was empty. Latency from last element to m_valid is 1 cycle.
  - Mask and err clear at T; a new frame may start at T+1 with no bubble.
- FIFO: 2 entries, ping-pong pointers plus count.
  - Pop when m_valid && m_ready.
  - Push when completion && (count<2 || pop). Simultaneous push and pop when full is legal; count stays 2.
  - m_data/m_err/m_valid are stable while m_valid && !m_ready.
- Overflow: completion while count==2 and no pop.
  - Vector discarded, FIFO unchanged.
  - ovf pulses 1 cycle and ovf_sticky sets.
  - ovf_clr in the same cycle as a new ovf: set wins.
- Reset mid-frame or with a non-empty FIFO: all partial and buffered data lost; no outputs asserted after release until a new frame completes.
- in_valid gaps within a frame are allowed; there is no timeout.

Test Plan:
- Basic: N=4, shift=0, in_idx 0..3 = 300,255,256,1, m_ready=1 -> one vector {255,255,255,1}, m_err=0, m_valid high exactly 1 cycle, 1 cycle after idx 3.
- Rounding: shift=1, elements 3,2,1,0 -> {2,1,1,0}; shift=15, element 65535 -> 2; shift changed mid-frame to 4 -> ignored, frame_shift=1 used.
- Backpressure/overflow: m_ready=0, three back-to-back complete frames -> m_valid=1, count=2, third dropped, ovf 1-cycle pulse, ovf_sticky=1. Then m_ready=1 -> first two vectors out in order, and ovf_clr -> sticky 0.
- Full with simultaneous pop: FIFO full, m_ready=1 on the cycle a third frame completes -> no ovf, all three vectors delivered in order.
- Protocol errors:
  - idx order 0,0,3 -> m_err=1, slots 1,2 = 0, slot 0 holds the second value.
  - idx 0,1,2,3 then 3 -> second frame completes with m_err=1.
- Async reset: rst asserted between idx 1 and 2 with one vector buffered -> m_valid=0 immediately. After release, a fresh 0..3 frame yields a clean vector with m_err=0.
